// File: rtl/chess_pkg.sv
// chess_pkg: shared definitions for the chess board co-processor.
//   - piece type codes and the 64-square board type
//   - serial command codes
//   - knight offset table and ray direction table as (dfile, drank) pairs
//   - attack-scan FSM state type
package chess_pkg;

    // Serial command codes (nibble 0 of a frame)
    localparam logic [3:0] CMD_WRITE  = 4'h1;
    localparam logic [3:0] CMD_READ   = 4'h2;
    localparam logic [3:0] CMD_QUERY  = 4'h3;
    localparam logic [3:0] CMD_RESULT = 4'h4;

    // Piece type field (bits 2:0 of a square); bit 3 is the colour, 0 white / 1 black
    localparam logic [2:0] PC_EMPTY  = 3'd0;
    localparam logic [2:0] PC_PAWN   = 3'd1;
    localparam logic [2:0] PC_KNIGHT = 3'd2;
    localparam logic [2:0] PC_BISHOP = 3'd3;
    localparam logic [2:0] PC_ROOK   = 3'd4;
    localparam logic [2:0] PC_QUEEN  = 3'd5;
    localparam logic [2:0] PC_KING   = 3'd6;
    localparam logic [2:0] PC_VOID   = 3'd7;  // reserved code, behaves as empty

    // Square index = rank*8 + file, a1 = 0, h8 = 63
    typedef logic [63:0][3:0] board_t;

    typedef logic signed [2:0] delta_t;

    typedef enum logic [1:0] {StIdle, StKnight, StRay} scan_state_e;

    function automatic logic piece_occupied(input logic [2:0] ptype);
        return (ptype != PC_EMPTY) && (ptype != PC_VOID);
    endfunction

    // Knight offsets, dfile component
    function automatic delta_t knight_df(input logic [2:0] i);
        case (i)
            3'd0:    return 3'sd1;
            3'd1:    return 3'sd2;
            3'd2:    return 3'sd2;
            3'd3:    return 3'sd1;
            3'd4:    return -3'sd1;
            3'd5:    return -3'sd2;
            3'd6:    return -3'sd2;
            default: return -3'sd1;
        endcase
    endfunction

    // Knight offsets, drank component
    function automatic delta_t knight_dr(input logic [2:0] i);
        case (i)
            3'd0:    return 3'sd2;
            3'd1:    return 3'sd1;
            3'd2:    return -3'sd1;
            3'd3:    return -3'sd2;
            3'd4:    return -3'sd2;
            3'd5:    return -3'sd1;
            3'd6:    return 3'sd1;
            default: return 3'sd2;
        endcase
    endfunction

    // Ray order N, NE, E, SE, S, SW, W, NW: odd indices are the diagonals
    function automatic delta_t ray_df(input logic [2:0] i);
        case (i)
            3'd0:    return 3'sd0;
            3'd1:    return 3'sd1;
            3'd2:    return 3'sd1;
            3'd3:    return 3'sd1;
            3'd4:    return 3'sd0;
            3'd5:    return -3'sd1;
            3'd6:    return -3'sd1;
            default: return -3'sd1;
        endcase
    endfunction

    function automatic delta_t ray_dr(input logic [2:0] i);
        case (i)
            3'd0:    return 3'sd1;
            3'd1:    return 3'sd1;
            3'd2:    return 3'sd0;
            3'd3:    return -3'sd1;
            3'd4:    return -3'sd1;
            3'd5:    return -3'sd1;
            3'd6:    return 3'sd0;
            default: return 3'sd1;
        endcase
    endfunction

endpackage

// File: rtl/chess_attack_scan.sv
// chess_attack_scan: sequential "is this square attacked by side X" engine.
// Examines one candidate square per clk: 8 knight squares, then the 8 rays.
//   clk, rst     : clock, async active-high reset
//   board_i      : live view of the 64-square board
//   target_i     : square under test (rank*8 + file)
//   side_i       : attacking colour, 0 white / 1 black
//   start_i      : latch target/side and (re)start the scan
//   abort_i      : drop the scan, clearing busy and valid
//   busy_o       : scan in progress
//   valid_o      : result available
//   attacked_o   : result, meaningful when valid_o
module chess_attack_scan
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  board_t     board_i,
    input  logic [5:0] target_i,
    input  logic       side_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       valid_o,
    output logic       attacked_o
);

    scan_state_e state_q;
    logic [2:0]  idx_q;     // knight offset or ray direction
    logic [2:0]  dist_q;    // ray step count, 1..7
    logic [2:0]  tfile_q;
    logic [2:0]  trank_q;
    logic        side_q;
    logic        busy_q;
    logic        valid_q;
    logic        attacked_q;

    delta_t            df;
    delta_t            dr;
    logic [2:0]        mult;
    logic signed [4:0] pf;
    logic signed [4:0] pr;
    logic              on_board;
    logic [3:0]        piece;
    logic [2:0]        ptype;
    logic              own;
    logic              diag;
    logic              adjacent;
    logic              pawn_dir_ok;
    logic              knight_hit;
    logic              ray_hit;
    logic              ray_stop;

    always_comb begin
        if (state_q == StKnight) begin
            df   = knight_df(idx_q);
            dr   = knight_dr(idx_q);
            mult = 3'd1;
        end else begin
            df   = ray_df(idx_q);
            dr   = ray_dr(idx_q);
            mult = dist_q;
        end
        // File and rank are computed separately, so file wrap-around cannot alias
        pf = $signed({2'b00, tfile_q}) + $signed({{2{df[2]}}, df}) * $signed({2'b00, mult});
        pr = $signed({2'b00, trank_q}) + $signed({{2{dr[2]}}, dr}) * $signed({2'b00, mult});
        on_board = (pf[4:3] == 2'b00) && (pr[4:3] == 2'b00);
        piece    = board_i[{pr[2:0], pf[2:0]}];
        ptype    = piece[2:0];
        own      = on_board && piece_occupied(ptype) && (piece[3] == side_q);
        diag     = idx_q[0];
        adjacent = (dist_q == 3'd1);
        // Pawns attack forward: a white attacker sits one rank below the target
        pawn_dir_ok = diag && (side_q ? (dr == 3'sd1) : (dr == -3'sd1));
        knight_hit  = on_board && (ptype == PC_KNIGHT) && (piece[3] == side_q);
        ray_hit = own && (
                      (!diag && ((ptype == PC_ROOK) || (ptype == PC_QUEEN)))
                   || ( diag && ((ptype == PC_BISHOP) || (ptype == PC_QUEEN)))
                   || (adjacent && (ptype == PC_KING))
                   || (adjacent && (ptype == PC_PAWN) && pawn_dir_ok));
        ray_stop = !on_board || piece_occupied(ptype) || (dist_q == 3'd7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            dist_q     <= 3'd1;
            tfile_q    <= '0;
            trank_q    <= '0;
            side_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            attacked_q <= 1'b0;
        end else if (start_i) begin
            state_q    <= StKnight;
            idx_q      <= '0;
            dist_q     <= 3'd1;
            tfile_q    <= target_i[2:0];
            trank_q    <= target_i[5:3];
            side_q     <= side_i;
            busy_q     <= 1'b1;
            valid_q    <= 1'b0;
            attacked_q <= 1'b0;
        end else if (abort_i) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            attacked_q <= 1'b0;
        end else begin
            case (state_q)
                StKnight: begin
                    if (knight_hit) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        attacked_q <= 1'b1;
                    end else if (idx_q == 3'd7) begin
                        state_q <= StRay;
                        idx_q   <= '0;
                        dist_q  <= 3'd1;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                StRay: begin
                    if (ray_hit) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        attacked_q <= 1'b1;
                    end else if (ray_stop) begin
                        if (idx_q == 3'd7) begin
                            state_q    <= StIdle;
                            busy_q     <= 1'b0;
                            valid_q    <= 1'b1;
                            attacked_q <= 1'b0;
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            dist_q <= 3'd1;
                        end
                    end else begin
                        dist_q <= dist_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign attacked_o = attacked_q;

endmodule

// File: rtl/chess_core.sv
// chess_core: chess board co-processor behind a 4-bit serial link (mode 0).
// Holds the input synchronisers, the frame/command decoder, the 64x4 board
// register array and the attack-scan engine.
//   clk   : system clock (at least 8x sck)
//   rst   : async active-high reset
//   sck   : serial clock, asynchronous to clk
//   cs_n  : frame select, active low; one command per low period
//   sdi   : serial data in, sampled on sck rising
//   sdo   : serial data out, updated after sck falling
module chess_core
    import chess_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] sdi,
    output logic [3:0] sdo
);

    localparam int unsigned SdiW = SYNC_STAGES * 4;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SdiW-1:0]        sdi_sync_q;
    logic                   sck_prev_q;

    logic       sck_s;
    logic       cs_s;
    logic [3:0] sdi_s;
    logic       sck_rise;
    logic       sck_fall;

    logic [3:0] cmd_q;
    logic [2:0] cnt_q;     // nibbles seen this frame, saturating at 4
    logic [5:0] ptr_q;     // board pointer for WRITE/READ
    logic [5:0] sq_q;
    logic       side_q;
    logic       start_q;
    logic       abort_q;
    logic [3:0] sdo_q;
    board_t     board_q;

    logic scan_busy;
    logic scan_valid;
    logic scan_attacked;

    // sck, cs_n and sdi share the same depth so data stays aligned with its edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= (sck_sync_q << 1) | SYNC_STAGES'(sck);
            cs_sync_q  <= (cs_sync_q << 1) | SYNC_STAGES'(cs_n);
            sdi_sync_q <= (sdi_sync_q << 4) | SdiW'(sdi);
            sck_prev_q <= sck_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SdiW-1 -: 4];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sq_q    <= '0;
            side_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            sdo_q   <= '0;
            board_q <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            if (cs_s) begin
                cnt_q <= '0;
                cmd_q <= '0;
                sdo_q <= '0;
            end else begin
                if (sck_rise) begin
                    if (cnt_q == 3'd0) begin
                        cmd_q   <= sdi_s;
                        cnt_q   <= 3'd1;
                        ptr_q   <= '0;
                        abort_q <= (sdi_s == CMD_WRITE);
                    end else begin
                        if (cnt_q != 3'd4) begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                        case (cmd_q)
                            CMD_WRITE: begin
                                board_q[ptr_q] <= sdi_s;
                                ptr_q          <= ptr_q + 6'd1;
                            end
                            CMD_QUERY: begin
                                case (cnt_q)
                                    3'd1: sq_q[5:4] <= sdi_s[1:0];
                                    3'd2: sq_q[3:0] <= sdi_s;
                                    3'd3: begin
                                        side_q  <= sdi_s[0];
                                        start_q <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                if (sck_fall) begin
                    case (cmd_q)
                        CMD_READ: begin
                            sdo_q <= board_q[ptr_q];
                            ptr_q <= ptr_q + 6'd1;
                        end
                        CMD_RESULT: sdo_q <= {scan_busy, 1'b0, scan_valid, scan_attacked};
                        default:    sdo_q <= '0;
                    endcase
                end
            end
        end
    end

    assign sdo = sdo_q;

    chess_attack_scan u_scan (
        .clk        (clk),
        .rst        (rst),
        .board_i    (board_q),
        .target_i   (sq_q),
        .side_i     (side_q),
        .start_i    (start_q),
        .abort_i    (abort_q),
        .busy_o     (scan_busy),
        .valid_o    (scan_valid),
        .attacked_o (scan_attacked)
    );

endmodule

// File: tb/tb_chess_core.sv
module tb_chess_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic [3:0] sdi;
    logic [3:0] sdo;

    always #5 clk = ~clk;

    chess_core #(.SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .sck  (sck),
        .cs_n (cs_n),
        .sdi  (sdi),
        .sdo  (sdo)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] model  [64];
    logic [3:0] tx_buf [66];
    logic [3:0] rx_buf [66];

    localparam int KDF [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    localparam int KDR [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    localparam int RDF [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    localparam int RDR [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    // Behavioural attack rules on the model board
    function automatic logic ref_attacked(input int tgt, input logic side);
        int tf, tr, f, r, t;
        logic [3:0] p;
        logic diag;
        tf = tgt % 8;
        tr = tgt / 8;
        for (int k = 0; k < 8; k++) begin
            f = tf + KDF[k];
            r = tr + KDR[k];
            if (f >= 0 && f < 8 && r >= 0 && r < 8) begin
                p = model[r * 8 + f];
                if (p[2:0] == 3'd2 && p[3] == side) return 1'b1;
            end
        end
        for (int d = 0; d < 8; d++) begin
            diag = (RDF[d] != 0) && (RDR[d] != 0);
            for (int n = 1; n < 8; n++) begin
                f = tf + n * RDF[d];
                r = tr + n * RDR[d];
                if (f < 0 || f > 7 || r < 0 || r > 7) break;
                p = model[r * 8 + f];
                t = int'(p[2:0]);
                if (t == 0 || t == 7) continue;
                if (p[3] == side) begin
                    if (!diag && (t == 4 || t == 5)) return 1'b1;
                    if (diag && (t == 3 || t == 5)) return 1'b1;
                    if (n == 1 && t == 6) return 1'b1;
                    if (n == 1 && t == 1 && diag && RDR[d] == (side ? 1 : -1)) return 1'b1;
                end
                break;
            end
        end
        return 1'b0;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: n nibbles from tx_buf, rx_buf[i] sampled after falling edge i
    task automatic frame(input int n);
        cs_n = 1'b0;
        wait_clk(2);
        for (int i = 0; i < n; i++) begin
            sdi = tx_buf[i];
            wait_clk(2);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            wait_clk(4);
            rx_buf[i] = sdo;
        end
        cs_n = 1'b1;
        sdi  = 4'h0;
        wait_clk(4);
    endtask

    task automatic write_board();
        tx_buf[0] = 4'h1;
        for (int i = 0; i < 64; i++) tx_buf[i + 1] = model[i];
        frame(65);
    endtask

    task automatic read_board();
        tx_buf[0] = 4'h2;
        for (int i = 1; i < 66; i++) tx_buf[i] = 4'h0;
        frame(65);
    endtask

    task automatic get_result(output logic [3:0] res);
        tx_buf[0] = 4'h4;
        frame(1);
        res = rx_buf[0];
    endtask

    task automatic query(input int tgt, input logic side);
        logic [5:0] t6;
        t6 = 6'(tgt);
        tx_buf[0] = 4'h3;
        tx_buf[1] = {2'b00, t6[5:4]};
        tx_buf[2] = t6[3:0];
        tx_buf[3] = {3'b000, side};
        frame(4);
    endtask

    // Query then poll for a bounded number of result frames
    task automatic query_poll(input int tgt, input logic side, output logic [3:0] res);
        query(tgt, side);
        res = 4'h8;
        for (int i = 0; i < 10 && res[3]; i++) get_result(res);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 4'h0;
    endtask

    task automatic start_position();
        logic [3:0] back [8];
        back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
        clear_model();
        for (int f = 0; f < 8; f++) begin
            model[f]      = back[f];
            model[8 + f]  = 4'h1;
            model[48 + f] = 4'h9;
            model[56 + f] = back[f] | 4'h8;
        end
    endtask

    task automatic test_reset();
        logic [3:0] res;
        rst  = 1'b1;
        sck  = 1'b0;
        cs_n = 1'b1;
        sdi  = 4'h0;
        wait_clk(3);
        vectors++;
        if (sdo !== 4'h0) begin
            $display("FAIL reset_sdo: got %h expected 0", sdo);
            miscompares++;
        end
        rst = 1'b0;
        wait_clk(2);
        clear_model();
        read_board();
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (rx_buf[i] !== 4'h0) begin
                $display("FAIL reset_board sq%0d: got %h expected 0", i, rx_buf[i]);
                miscompares++;
            end
        end
        get_result(res);
        vectors++;
        if (res !== 4'h0) begin
            $display("FAIL reset_result: got %h expected 0", res);
            miscompares++;
        end
    endtask

    task automatic test_write_read();
        start_position();
        write_board();
        read_board();
        for (int i = 0; i < 65; i++) begin
            vectors++;
            if (rx_buf[i] !== model[i % 64]) begin
                $display("FAIL start_readback nibble%0d: got %h expected %h",
                         i, rx_buf[i], model[i % 64]);
                miscompares++;
            end
        end
        vectors++;
        if (sdo !== 4'h0) begin
            $display("FAIL idle_sdo: got %h expected 0", sdo);
            miscompares++;
        end
    endtask

    task automatic test_query_start();
        logic [3:0] res;
        query_poll(20, 1'b0, res);
        vectors++;
        if (res !== 4'h3) begin
            $display("FAIL query_e3_white: got %h expected 3", res);
            miscompares++;
        end
        query_poll(28, 1'b0, res);
        vectors++;
        if (res !== 4'h2) begin
            $display("FAIL query_e4_white: got %h expected 2", res);
            miscompares++;
        end
    endtask

    task automatic test_ray_block();
        logic [3:0] res;
        clear_model();
        model[0]  = 4'h4;
        model[24] = 4'h9;
        write_board();
        query_poll(56, 1'b0, res);
        vectors++;
        if (res !== 4'h2) begin
            $display("FAIL rook_blocked: got %h expected 2", res);
            miscompares++;
        end
        model[24] = 4'h0;
        write_board();
        query_poll(56, 1'b0, res);
        vectors++;
        if (res !== 4'h3) begin
            $display("FAIL rook_open: got %h expected 3", res);
            miscompares++;
        end
    endtask

    task automatic test_knight_wrap();
        logic [3:0] res;
        clear_model();
        model[7] = 4'h2;
        write_board();
        query_poll(16, 1'b0, res);
        vectors++;
        if (res !== 4'h2) begin
            $display("FAIL knight_no_wrap: got %h expected 2", res);
            miscompares++;
        end
        query_poll(22, 1'b0, res);
        vectors++;
        if (res !== 4'h3) begin
            $display("FAIL knight_g3: got %h expected 3", res);
            miscompares++;
        end
        query_poll(22, 1'b1, res);
        vectors++;
        if (res !== 4'h2) begin
            $display("FAIL knight_wrong_side: got %h expected 2", res);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] res;
        clear_model();
        write_board();
        // Empty board, centre target: long scan, so the result frame lands mid-scan
        query(27, 1'b0);
        get_result(res);
        vectors++;
        if (res !== 4'h8) begin
            $display("FAIL busy_result: got %h expected 8", res);
            miscompares++;
        end
        for (int i = 0; i < 10 && res[3]; i++) get_result(res);
        vectors++;
        if (res !== 4'h2) begin
            $display("FAIL busy_then_done: got %h expected 2", res);
            miscompares++;
        end
        query(27, 1'b0);
        tx_buf[0] = 4'h1;
        frame(1);
        get_result(res);
        vectors++;
        if (res !== 4'h0) begin
            $display("FAIL write_aborts_scan: got %h expected 0", res);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] res;
        start_position();
        write_board();
        cs_n = 1'b0;
        wait_clk(2);
        sdi = 4'h1;
        wait_clk(2);
        sck = 1'b1;
        wait_clk(4);
        sck = 1'b0;
        wait_clk(4);
        sdi = 4'hF;
        wait_clk(2);
        sck = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(2);
        vectors++;
        if (sdo !== 4'h0) begin
            $display("FAIL midframe_reset_sdo: got %h expected 0", sdo);
            miscompares++;
        end
        sck = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        cs_n = 1'b1;
        sdi = 4'h0;
        wait_clk(4);
        clear_model();
        read_board();
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (rx_buf[i] !== 4'h0) begin
                $display("FAIL midframe_reset_board sq%0d: got %h expected 0", i, rx_buf[i]);
                miscompares++;
            end
        end
        get_result(res);
        vectors++;
        if (res !== 4'h0) begin
            $display("FAIL midframe_reset_result: got %h expected 0", res);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [3:0] res;
        logic [3:0] exp;
        int         tgt;
        logic       side;
        int         dens;
        for (int it = 0; it < 12; it++) begin
            dens = 10 + it * 6;
            for (int i = 0; i < 64; i++)
                model[i] = ($urandom_range(0, 99) < dens) ? 4'($urandom_range(0, 15)) : 4'h0;
            write_board();
            if (it < 3) begin
                read_board();
                for (int i = 0; i < 64; i++) begin
                    vectors++;
                    if (rx_buf[i] !== model[i]) begin
                        $display("FAIL rand_readback it%0d sq%0d: got %h expected %h",
                                 it, i, rx_buf[i], model[i]);
                        miscompares++;
                    end
                end
            end
            for (int q = 0; q < 4; q++) begin
                tgt  = int'($urandom_range(0, 63));
                side = 1'($urandom_range(0, 1));
                exp  = {3'b001, ref_attacked(tgt, side)};
                query_poll(tgt, side, res);
                vectors++;
                if (res !== exp) begin
                    $display("FAIL rand_query it%0d sq%0d side%0d: got %h expected %h",
                             it, tgt, side, res, exp);
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_query_start();
        test_ray_block();
        test_knight_wrap();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chess_core.md
Name: chess_core

Overview:
- Chess board co-processor behind a 4-bit-wide SPI-style serial link (sck, cs_n, sdi[3:0] in; sdo[3:0] out).
- The host loads a 64-square board, reads it back, and asks whether a square is attacked by a given side.
- The block sits inside the tt_um_chess top-level wrapper, which maps:
  - sdi[1:0] to ui_in[7:6], sck to ui_in[5], cs_n to ui_in[4], sdi[3:2] to uio_in[1:0];
  - sdo to uo_out[7:4]; uo_out[3:0] is 0, and uio_oe is 0.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sck, cs_n and sdi.

Ports:
- clk  in  1  system clock. Single clock domain. f_clk must be at least 8x f_sck.
- rst  in  1  reset, asynchronous, active-high.
- sck  in  1  serial clock, asynchronous to clk.
- cs_n  in  1  chip select, active-low. Framing: one command per low period.
- sdi  in  4  serial data in, one nibble per sck rising edge.
- sdo  out  4  serial data out, one nibble per sck falling edge.

Behaviour:
- Input sync and framing:
  - sck, cs_n and sdi pass through SYNC_STAGES flops; sck edges are detected in the clk domain.
  - cs_n high clears the nibble counter and the command register, and drives sdo to 0.
- Timing: mode 0. Sample sdi on sck rising. sdo updates within 3 clk cycles after a sck falling edge.
- Nibble 0 of each frame is the command. Unknown commands ignore the rest of the frame; sdo stays 0.
- Piece code (4 bits):
  - bit3 = colour (0 white, 1 black).
  - bits2:0: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 treated as empty.
- Square index = rank*8 + file; a1 = 0, h8 = 63.
- CMD 0x1 WRITE_BOARD:
  - Following nibbles write squares 0, 1, 2, ... in order. The index wraps 63 -> 0.
  - Each write takes effect 1 clk after the rising edge that sampled it.
  - Aborting the frame early keeps the squares already written.
  - If a scan is busy, it is aborted: busy=0, valid=0.
- CMD 0x2 READ_BOARD:
  - The first falling edge after the command nibble presents square 0.
  - Each later falling edge advances one square, wrapping 63 -> 0.
- CMD 0x3 QUERY:
  - Next two nibbles are {00, sq[5:4]} then sq[3:0]. The third nibble is side: bit0, 0 = white attacker, 1 = black attacker.
  - On the third nibble: busy=1, valid=0, and the scan starts.
  - A QUERY while busy restarts the scan.
- CMD 0x4 READ_RESULT: the first falling edge after the command presents {busy, 0, valid, attacked}. It repeats on later edges.
- Attack scan (sequential, one square examined per clk):
  - Phase 1, 8 clk: check the 8 knight squares. Skip off-board squares and file wrap-around (|dfile| must match the offset).
  - Phase 2: walk 8 rays (N, NE, E, SE, S, SW, W, NW) one step per clk. A ray stops at the board edge or at the first occupied square.
  - The first piece found on a ray is an attacker of the given side if any of these holds:
    - orthogonal ray and rook/queen;
    - diagonal ray and bishop/queen;
    - king at distance 1;
    - white pawn at distance 1 on SW/SE of the target;
    - black pawn at distance 1 on NW/NE of the target.
  - The scan may terminate early on the first hit.
  - Done: busy=0, valid=1, attacked set. Worst case is 64 clk plus at most 2 clk overhead.
  - The target square's own contents are ignored.
- Reset values: all squares 0 (empty), busy=0, valid=0, attacked=0, sdo=0, command/counters 0.
- Reset mid-frame or mid-scan behaves identically to power-on reset.

Decomposition:
- chess_pkg holds:
  - piece and colour codes;
  - command codes (CMD_WRITE=1, CMD_READ=2, CMD_QUERY=3, CMD_RESULT=4);
  - the knight offset table and the ray (dfile, drank) direction table.
- One sub-module, chess_attack_scan:
  - inputs: board view, target, side, start/abort;
  - outputs: busy, valid, attacked.
- The top level holds the sync/SPI front end and the 64x4 board register array.

Test Plan:
- Reset, then READ_BOARD 64 nibbles -> all 0x0; READ_RESULT -> 0x0.
- WRITE_BOARD with the standard start position (square 0 = 0x4 rook, 4 = 0x6 king, 60 = 0xE, ...), then READ_BOARD -> identical 64 nibbles. A 65th nibble reads square 0 again.
- Start position, QUERY sq=20 (e3) side=white, then poll READ_RESULT -> 0x3 (pawn attack). QUERY sq=28 (e4) side=white -> 0x2 (not attacked).
- Board with only a white rook a1=0x4, black pawn a4=0x9, target a8 (56), side=white -> 0x2 (ray blocked). Remove the pawn -> 0x3.
- Knight at h1 (7, 0x2), target a3 (16) -> 0x2 (no file wrap). Target g3 (22) -> 0x3.
- QUERY immediately followed by READ_RESULT within 10 clk -> 0x8 (busy). WRITE_BOARD mid-scan -> 0x0. Assert rst mid-frame -> board cleared, sdo 0.
